// File: rtl/conv_pad_stream.sv
// Streaming border handler: tracks the kernel-window centre across a frame and
// pads out-of-image taps (zero / constant / replicate / bypass) behind a skid stage.
module conv_pad_stream #(
    parameter  int PIXEL_W  = 8,
    parameter  int KERNEL_R = 2,
    parameter  int IMG_MAX  = 1024,
    localparam int D        = 2 * KERNEL_R + 1,
    localparam int CNT_W    = $clog2(IMG_MAX + 1),
    localparam int KW       = D * D * PIXEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cfg_width_i,
    input  logic [CNT_W-1:0]   cfg_height_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [PIXEL_W-1:0] cfg_const_i,
    input  logic               in_vld_i,
    output logic               in_rdy_o,
    input  logic               in_sof_i,
    input  logic [KW-1:0]      in_kernel_i,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic [KW-1:0]      out_kernel_o,
    output logic               out_sof_o,
    output logic               out_eol_o,
    output logic               out_eof_o,
    output logic               err_o
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    typedef struct packed {
        logic [KW-1:0] kernel;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_BYP   = 2'd3;

    // Tap [m][n] sits at image (r+R-m, c+R-n); replicate re-reads the tap at the clamped coordinate.
    function automatic logic [KW-1:0] pad_window(
        input logic [KW-1:0]      win,
        input int                 r,
        input int                 c,
        input int                 w,
        input int                 h,
        input logic [1:0]         mode,
        input logic [PIXEL_W-1:0] k
    );
        logic [KW-1:0] res;
        int row, col, rc, cc, mm, nn;
        res = win;
        for (int m = 0; m < D; m++) begin
            for (int n = 0; n < D; n++) begin
                row = r + KERNEL_R - m;
                col = c + KERNEL_R - n;
                if (mode != MODE_BYP && (row < 0 || row >= h || col < 0 || col >= w)) begin
                    if (mode == MODE_ZERO) begin
                        res[(m*D+n)*PIXEL_W +: PIXEL_W] = '0;
                    end else if (mode == MODE_CONST) begin
                        res[(m*D+n)*PIXEL_W +: PIXEL_W] = k;
                    end else begin
                        rc = (row < 0) ? 0 : ((row >= h) ? h - 1 : row);
                        cc = (col < 0) ? 0 : ((col >= w) ? w - 1 : col);
                        mm = r + KERNEL_R - rc;
                        nn = c + KERNEL_R - cc;
                        if (mm >= 0 && mm < D && nn >= 0 && nn < D)
                            res[(m*D+n)*PIXEL_W +: PIXEL_W] = win[(mm*D+nn)*PIXEL_W +: PIXEL_W];
                    end
                end
            end
        end
        return res;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_row, r_col, w_row_nxt, w_col_nxt;
    logic [CNT_W-1:0]     r_width, r_height;
    logic [1:0]           r_mode;
    logic [PIXEL_W-1:0]   r_const;
    logic                 r_err, r_live;
    beat_t                r_out, r_skid, w_beat;
    logic                 r_out_vld, r_skid_vld;

    logic                 w_accept, w_start, w_fwd, w_eol, w_eof, w_err_set;
    logic [CNT_W-1:0]     w_pos_r, w_pos_c, w_width, w_height;
    logic [1:0]           w_mode;
    logic [PIXEL_W-1:0]   w_const;

    assign in_rdy_o  = r_live & ~r_skid_vld;
    assign w_accept  = in_vld_i & in_rdy_o;
    assign w_start   = in_sof_i & (cfg_width_i != '0) & (cfg_height_i != '0);
    assign w_err_set = w_accept & (((r_state == S_IDLE) & ~w_start) | ((r_state == S_ACTIVE) & in_sof_i));

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_fwd       = 1'b0;
        w_pos_r     = r_row;
        w_pos_c     = r_col;
        w_width     = r_width;
        w_height    = r_height;
        w_mode      = r_mode;
        w_const     = r_const;
        if (w_start) begin
            w_pos_r  = '0;
            w_pos_c  = '0;
            w_width  = cfg_width_i;
            w_height = cfg_height_i;
            w_mode   = cfg_mode_i;
            w_const  = cfg_const_i;
        end
        w_eol = (w_pos_c == w_width - CNT_W'(1));
        w_eof = w_eol & (w_pos_r == w_height - CNT_W'(1));
        if (w_accept) begin
            if (w_start || (r_state == S_ACTIVE && !in_sof_i)) begin
                w_fwd = 1'b1;
                if (w_eof) begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else if (w_eol) begin
                    w_state_nxt = S_ACTIVE;
                    w_row_nxt   = w_pos_r + CNT_W'(1);
                    w_col_nxt   = '0;
                end else begin
                    w_state_nxt = S_ACTIVE;
                    w_row_nxt   = w_pos_r;
                    w_col_nxt   = w_pos_c + CNT_W'(1);
                end
            end else begin
                w_state_nxt = S_IDLE;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end
        end
        w_beat.kernel = pad_window(in_kernel_i, int'(w_pos_r), int'(w_pos_c),
                                   int'(w_width), int'(w_height), w_mode, w_const);
        w_beat.sof    = w_start;
        w_beat.eol    = w_eol;
        w_beat.eof    = w_eof;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_mode   <= '0;
            r_const  <= '0;
            r_err    <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            if (w_err_set)
                r_err <= 1'b1;
            if (w_accept && w_start) begin
                r_width  <= cfg_width_i;
                r_height <= cfg_height_i;
                r_mode   <= cfg_mode_i;
                r_const  <= cfg_const_i;
            end
        end
    end

    // Skid stage: the main register drains first; the skid only fills while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_out_vld || out_rdy_i) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= w_accept & w_fwd;
                if (w_accept && w_fwd)
                    r_out <= w_beat;
            end
        end else if (w_accept && w_fwd) begin
            r_skid     <= w_beat;
            r_skid_vld <= 1'b1;
        end
    end

    assign out_vld_o    = r_out_vld;
    assign out_kernel_o = r_out.kernel;
    assign out_sof_o    = r_out_vld & r_out.sof;
    assign out_eol_o    = r_out_vld & r_out.eol;
    assign out_eof_o    = r_out_vld & r_out.eof;
    assign err_o        = r_err;

endmodule

// File: tb/tb_conv_pad_stream.sv
// Self-checking bench for conv_pad_stream: directed frames scored against a
// coordinate-level padding model, plus literal tap checks that pin the model.
module tb_conv_pad_stream;

    localparam int PW      = 8;
    localparam int R       = 2;
    localparam int D       = 2 * R + 1;
    localparam int IMG_MAX = 1024;
    localparam int CW      = $clog2(IMG_MAX + 1);
    localparam int KW      = D * D * PW;

    typedef struct {
        logic [KW-1:0] k;
        logic [2:0]    f;   // {sof, eol, eof}
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_width_i, cfg_height_i;
    logic [1:0]    cfg_mode_i;
    logic [PW-1:0] cfg_const_i;
    logic          in_vld_i, in_rdy_o, in_sof_i;
    logic [KW-1:0] in_kernel_i;
    logic          out_vld_o, out_rdy_i;
    logic [KW-1:0] out_kernel_o;
    logic          out_sof_o, out_eol_o, out_eof_o, err_o;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t got[$];
    logic  stall_en = 1'b0;

    conv_pad_stream #(.PIXEL_W(PW), .KERNEL_R(R), .IMG_MAX(IMG_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .cfg_mode_i(cfg_mode_i), .cfg_const_i(cfg_const_i),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_sof_i(in_sof_i),
        .in_kernel_i(in_kernel_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_kernel_o(out_kernel_o),
        .out_sof_o(out_sof_o), .out_eol_o(out_eol_o), .out_eof_o(out_eof_o),
        .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] tap(input logic [KW-1:0] k, input int m, input int n);
        return k[(m*D+n)*PW +: PW];
    endfunction

    // Model: each tap has an image coordinate; replicate finds the tap that holds the nearest in-image pixel.
    function automatic logic [KW-1:0] model_pad(input logic [KW-1:0] win, input int r, input int c,
                                                input int w, input int h, input int mode,
                                                input logic [PW-1:0] kc);
        logic [KW-1:0] res;
        int row, col, tr, tc;
        res = win;
        for (int m = 0; m < D; m++) begin
            for (int n = 0; n < D; n++) begin
                row = r + R - m;
                col = c + R - n;
                if (mode != 3 && !(row >= 0 && row < h && col >= 0 && col < w)) begin
                    if (mode == 0) res[(m*D+n)*PW +: PW] = '0;
                    else if (mode == 1) res[(m*D+n)*PW +: PW] = kc;
                    else begin
                        tr = (row < 0) ? 0 : ((row > h - 1) ? h - 1 : row);
                        tc = (col < 0) ? 0 : ((col > w - 1) ? w - 1 : col);
                        for (int mm = 0; mm < D; mm++)
                            for (int nn = 0; nn < D; nn++)
                                if (r + R - mm == tr && c + R - nn == tc)
                                    res[(m*D+n)*PW +: PW] = win[(mm*D+nn)*PW +: PW];
                    end
                end
            end
        end
        return res;
    endfunction

    // pat 0: every tap = fill; pat 1: tap[m][n] = m*5+n; otherwise random
    function automatic logic [KW-1:0] make_win(input int pat, input logic [PW-1:0] fill);
        logic [KW-1:0] res;
        res = '0;
        for (int m = 0; m < D; m++)
            for (int n = 0; n < D; n++)
                res[(m*D+n)*PW +: PW] = (pat == 0) ? fill : (pat == 1) ? PW'(m*5+n) : PW'($urandom);
        return res;
    endfunction

    task automatic send_beat(input logic [KW-1:0] win, input logic sof, input logic expect_out, input beat_t e);
        int n;
        n = 0;
        in_vld_i    = 1'b1;
        in_sof_i    = sof;
        in_kernel_i = win;
        while (!in_rdy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy_o) begin
            n_vec++;
            n_err++;
            $display("FAIL in_rdy_timeout: in_rdy_o still 0 after %0d cycles, expected 1", n);
        end else if (expect_out) begin
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int mode, input logic [PW-1:0] kc,
                              input int pat, input logic [PW-1:0] fill, input int nbeats,
                              input logic chk_lat);
        beat_t         e;
        logic [KW-1:0] win;
        cfg_width_i  = CW'(w);
        cfg_height_i = CW'(h);
        cfg_mode_i   = 2'(mode);
        cfg_const_i  = kc;
        for (int i = 0; i < nbeats; i++) begin
            win   = make_win(pat, fill);
            e.k   = model_pad(win, i / w, i % w, w, h, mode, kc);
            e.f   = {i == 0, (i % w) == w - 1, i == w * h - 1};
            send_beat(win, i == 0, 1'b1, e);
            if (i == 0) begin
                if (chk_lat) check("latency_1", KW'({out_vld_o, out_sof_o}), KW'(2'b11));
                // config must have been captured on the SOF beat only
                cfg_width_i  = CW'(1);
                cfg_height_i = CW'(1);
                cfg_mode_i   = 2'd3;
                cfg_const_i  = 8'hEE;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", KW'(exp_q.size()), KW'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        out_rdy_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: scores every transfer and checks the output holds while stalled.
    initial begin
        logic          stalled;
        logic [KW-1:0] prev_k;
        logic [2:0]    prev_f;
        beat_t         e, g;
        stalled = 1'b0;
        prev_k  = '0;
        prev_f  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_hold_vld", KW'(out_vld_o), KW'(1'b1));
                check("stall_hold_kernel", out_kernel_o, prev_k);
                check("stall_hold_flags", KW'({out_sof_o, out_eol_o, out_eof_o}), KW'(prev_f));
            end
            if (out_vld_o && out_rdy_i) begin
                g.k = out_kernel_o;
                g.f = {out_sof_o, out_eol_o, out_eof_o};
                got.push_back(g);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_beat: output beat %h with no expected beat pending", out_kernel_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_kernel", g.k, e.k);
                    check("beat_flags", KW'(g.f), KW'(e.f));
                end
            end
            stalled = out_vld_o && !out_rdy_i;
            prev_k  = out_kernel_o;
            prev_f  = {out_sof_o, out_eol_o, out_eof_o};
        end
    end

    initial begin
        beat_t dummy;
        dummy.k      = '0;
        dummy.f      = '0;
        in_vld_i     = 1'b0;
        in_sof_i     = 1'b0;
        in_kernel_i  = '0;
        cfg_width_i  = '0;
        cfg_height_i = '0;
        cfg_mode_i   = '0;
        cfg_const_i  = '0;
        out_rdy_i    = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_rdy", KW'(in_rdy_o), KW'(0));
        check("rst_out_vld", KW'(out_vld_o), KW'(0));
        check("rst_err", KW'(err_o), KW'(0));
        check("rst_kernel", out_kernel_o, KW'(0));
        check("rst_flags", KW'({out_sof_o, out_eol_o, out_eof_o}), KW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_release", KW'(in_rdy_o), KW'(1));

        // Mode 0, 5x5, all taps 0xFF
        got.delete();
        send_frame(5, 5, 0, 8'h00, 0, 8'hFF, 25, 1'b1);
        drain();
        check("m0_beat_count", KW'(got.size()), KW'(25));
        if (got.size() == 25) begin
            check("m0_00_tap33", KW'(tap(got[0].k, 3, 3)), KW'(8'h00));
            check("m0_00_tap40", KW'(tap(got[0].k, 4, 0)), KW'(8'h00));
            check("m0_00_tap04", KW'(tap(got[0].k, 0, 4)), KW'(8'h00));
            check("m0_00_tap22", KW'(tap(got[0].k, 2, 2)), KW'(8'hFF));
            check("m0_00_tap00", KW'(tap(got[0].k, 0, 0)), KW'(8'hFF));
            check("m0_22_full", got[12].k, {KW{1'b1}});
            check("m0_flags_0", KW'(got[0].f), KW'(3'b100));
            check("m0_flags_3", KW'(got[3].f), KW'(3'b000));
            check("m0_flags_4", KW'(got[4].f), KW'(3'b010));
            check("m0_flags_24", KW'(got[24].f), KW'(3'b011));
        end

        // Mode 1, const 0x5A, 3x3
        got.delete();
        send_frame(3, 3, 1, 8'h5A, 0, 8'h11, 9, 1'b0);
        drain();
        if (got.size() == 9) begin
            check("m1_00_tap32", KW'(tap(got[0].k, 3, 2)), KW'(8'h5A));
            check("m1_00_tap23", KW'(tap(got[0].k, 2, 3)), KW'(8'h5A));
            check("m1_00_tap22", KW'(tap(got[0].k, 2, 2)), KW'(8'h11));
            check("m1_11_tap02", KW'(tap(got[4].k, 0, 2)), KW'(8'h5A));
            check("m1_11_tap42", KW'(tap(got[4].k, 4, 2)), KW'(8'h5A));
            check("m1_11_tap20", KW'(tap(got[4].k, 2, 0)), KW'(8'h5A));
            check("m1_11_tap24", KW'(tap(got[4].k, 2, 4)), KW'(8'h5A));
            check("m1_11_tap13", KW'(tap(got[4].k, 1, 3)), KW'(8'h11));
        end else check("m1_beat_count", KW'(got.size()), KW'(9));

        // Mode 2, tap[m][n] = m*5+n, 8x8
        got.delete();
        send_frame(8, 8, 2, 8'h00, 1, 8'h00, 64, 1'b0);
        drain();
        if (got.size() == 64) begin
            check("m2_00_tap44", KW'(tap(got[0].k, 4, 4)), KW'(8'd12));
            check("m2_00_tap34", KW'(tap(got[0].k, 3, 4)), KW'(8'd12));
            check("m2_00_tap31", KW'(tap(got[0].k, 3, 1)), KW'(8'd11));
            check("m2_00_tap40", KW'(tap(got[0].k, 4, 0)), KW'(8'd10));
            check("m2_00_tap11", KW'(tap(got[0].k, 1, 1)), KW'(8'd6));
        end else check("m2_beat_count", KW'(got.size()), KW'(64));

        // Random output stalls over three back-to-back 4x4 frames
        got.delete();
        stall_en = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(4, 4, 0, 8'h00, 2, 8'h00, 16, 1'b0);
        drain();
        stall_en = 1'b0;
        @(negedge clk);
        check("stall_beat_count", KW'(got.size()), KW'(48));

        // Non-SOF beat out of reset is dropped
        do_reset();
        send_beat(make_win(0, 8'h77), 1'b0, 1'b0, dummy);
        check("drop_no_vld", KW'(out_vld_o), KW'(0));
        check("drop_err", KW'(err_o), KW'(1));
        repeat (3) @(negedge clk);

        // SOF mid-frame at (1,2) restarts the frame
        do_reset();
        got.delete();
        send_frame(4, 4, 0, 8'h00, 2, 8'h00, 6, 1'b0);
        check("pre_restart_err", KW'(err_o), KW'(0));
        send_frame(2, 2, 2, 8'h00, 1, 8'h00, 4, 1'b0);
        drain();
        check("restart_err", KW'(err_o), KW'(1));
        if (got.size() == 10) check("restart_sof", KW'(got[6].f), KW'(3'b100));
        else check("restart_beat_count", KW'(got.size()), KW'(10));

        // W=H=1: one beat, all flags, only the centre tap survives
        got.delete();
        send_frame(1, 1, 0, 8'h00, 0, 8'h33, 1, 1'b0);
        drain();
        if (got.size() == 1) begin
            check("one_px_kernel", got[0].k, KW'(8'h33) << ((2*D+2)*PW));
            check("one_px_flags", KW'(got[0].f), KW'(3'b111));
        end else check("one_px_count", KW'(got.size()), KW'(1));

        // Reset mid-frame discards in-flight beats; next frame is clean
        send_frame(4, 4, 0, 8'h00, 2, 8'h00, 3, 1'b0);
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_vld", KW'(out_vld_o), KW'(0));
        check("midrst_rdy", KW'(in_rdy_o), KW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        got.delete();
        send_frame(2, 2, 1, 8'hC3, 2, 8'h00, 4, 1'b1);
        drain();
        check("post_rst_count", KW'(got.size()), KW'(4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_pad_stream.md
Name: conv_pad_stream

Overview:
- Streaming border handler for the convolution datapath, parametrised in pixel width, kernel radius and maximum image size.
- Accepts one (2R+1)x(2R+1) kernel window per beat and tracks the window-centre position internally with row/column counters.
- Applies one of four padding modes to out-of-image taps: zero, constant, replicate (clamp), bypass.
- Output is registered behind a valid/ready skid stage; sits between the line-buffer window generator and the MAC array.

Parameters:
- PIXEL_W, 8, bits per pixel.
- KERNEL_R, 2, kernel radius; diameter D = 2*KERNEL_R+1.
- IMG_MAX, 1024, maximum image width/height; CNT_W = $clog2(IMG_MAX+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_width_i  in  CNT_W  image width W; sampled on SOF beat.
- cfg_height_i  in  CNT_W  image height H; sampled on SOF beat.
- cfg_mode_i  in  2  0 zero, 1 constant, 2 replicate, 3 bypass; sampled on SOF beat.
- cfg_const_i  in  PIXEL_W  pad value for mode 1; sampled on SOF beat.
- in_vld_i  in  1  input beat valid.
- in_rdy_o  out  1  input ready.
- in_sof_i  in  1  beat is the first window (centre 0,0) of a frame.
- in_kernel_i  in  D*D*PIXEL_W  window, tap [m][n] at bits ((m*D+n)*PIXEL_W) +: PIXEL_W.
- out_vld_o  out  1  output valid.
- out_rdy_i  in  1  output ready.
- out_kernel_o  out  D*D*PIXEL_W  padded window, same layout.
- out_sof_o / out_eol_o / out_eof_o  out  1 each  first beat of frame / last beat of row / last beat of frame.
- err_o  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Tap geometry, window centre (r,c): tap [m][n] maps to image row r+R-m and column c+R-n (m=D-1 north, n=D-1 west). Tap is in-image iff 0<=row<H and 0<=col<W.
- Mode 0: out-of-image taps = 0.
- Mode 1: out-of-image taps = cfg_const.
- Mode 2: out-of-image tap takes the value of tap [m'][n'], where row/col are clamped to [0,H-1]/[0,W-1] and mapped back to indices. Corners clamp on both axes.
- Mode 3: window passes unchanged; positions and flags are still tracked.
- FSM IDLE/ACTIVE; reset -> IDLE.
- IDLE, accepted beat with in_sof_i=1 and W,H nonzero: latch config, set r=c=0, forward the beat with out_sof_o=1, go to ACTIVE.
- IDLE, accepted beat with in_sof_i=0, or W==0 or H==0: beat is consumed and dropped, err_o set, stay IDLE.
- ACTIVE, each accepted beat: c increments. At c==W-1: out_eol_o=1, c->0, r increments. At r==H-1 and c==W-1: out_eof_o=1, go to IDLE.
- ACTIVE, in_sof_i=1: err_o set, frame restarts from that beat exactly as an IDLE SOF (new config, r=c=0).
- Counters, mode and config registers change only on an accepted beat (in_vld_i & in_rdy_o).
- Pipeline: masking is combinational into a main output register plus one skid register. Latency is 1 cycle from accept to out_vld_o when unstalled. Sustains 1 beat/cycle.
- in_rdy_o = skid register empty. Output holds stable while out_vld_o & ~out_rdy_i. No beats lost or reordered.
- Reset: out_vld_o=0, out_sof/eol/eof=0, err_o=0, in_rdy_o=0 while rst_n low and 1 the cycle after release. out_kernel_o=0. Counters 0. Mid-frame reset discards all in-flight beats.
- Degenerate sizes: W<D or H<D is legal. W=H=1 gives one beat with sof, eol and eof all 1.

Test Plan:
- R=2, mode 0, W=H=5, all taps 0xFF, no stall -> 25 beats, latency 1; beat (0,0) rows m=3,4 and cols n=3,4 are 0; beat (2,2) all 0xFF; eol on beats 5/10/15/20/25, eof on 25.
- Mode 1, const 0x5A, W=H=3 -> beat (0,0) north/west taps = 0x5A; beat (1,1) rows m=0,4 and cols n=0,4 = 0x5A; remaining taps unchanged.
- Mode 2, tap[m][n] = m*5+n, W=H=8, beat (0,0) -> rows m=3,4 take row m=2 values; corner tap[4][4] = 12 (= tap[2][2]).
- Random out_rdy_i (50%) over three back-to-back 4x4 frames in mode 0 -> output sequence identical to the no-stall run, no drops or duplicates, out_kernel_o stable while stalled.
- Beat with in_sof_i=0 after reset -> dropped, err_o=1, no out_vld_o. SOF mid-frame at (1,2) -> err_o=1, next output has out_sof_o=1 and counters restart.
- W=H=1 mode 0 -> single beat with sof=eol=eof=1, only tap [2][2] nonzero. rst_n low mid-frame -> out_vld_o=0 next cycle, next frame processes normally.
